// File: rtl/score_packer.sv
// Serial-to-parallel score packer feeding the max-reduction tree; collect + hold double buffer.
// Optional floor suppression via `SCORE_PACKER_THRESH_EN` (adds the thresh input).
module score_packer #(
  parameter int NUM = 18,
  parameter int LEN = 16,
  parameter int CW  = $clog2(NUM+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [LEN-1:0]     s_data,
  input  logic               s_last,
  output logic               a_valid,
  input  logic               a_ready,
  output logic [NUM*LEN-1:0] a,
  output logic [CW-1:0]      a_cnt,
  output logic               a_last
`ifdef SCORE_PACKER_THRESH_EN
  ,
  input  logic [LEN-1:0]     thresh
`endif
);
  typedef enum logic {S_COLLECT, S_WAIT} state_t;

  state_t             r_state, w_state_nx;
  logic               r_live;
  logic [CW-1:0]      r_cnt;
  logic [NUM*LEN-1:0] r_coll;
  logic               r_last;
  logic               r_a_valid;
  logic [NUM*LEN-1:0] r_a;
  logic [CW-1:0]      r_a_cnt;
  logic               r_a_last;

  logic               w_acc, w_done, w_hold_free, w_xfer;
  logic [LEN-1:0]     w_word;
  logic [NUM*LEN-1:0] w_coll_ins, w_xfer_data;
  logic [CW-1:0]      w_xfer_cnt;
  logic               w_xfer_last;

  // r_live keeps s_ready low until the first edge after reset release
  assign s_ready     = r_live && (r_state == S_COLLECT);
  assign w_acc       = s_valid && s_ready;
  assign w_done      = w_acc && ((r_cnt == CW'(NUM-1)) || s_last);
  assign w_hold_free = !r_a_valid || a_ready;

`ifdef SCORE_PACKER_THRESH_EN
  assign w_word = (s_data < thresh) ? '0 : s_data;
`else
  assign w_word = s_data;
`endif

  // slot k lives at the MSB end, first word highest
  always_comb begin
    w_coll_ins = r_coll;
    for (int k = 0; k < NUM; k++)
      if (r_cnt == CW'(k)) w_coll_ins[(NUM-1-k)*LEN +: LEN] = w_word;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_xfer      = 1'b0;
    w_xfer_data = w_coll_ins;
    w_xfer_cnt  = r_cnt + CW'(1);
    w_xfer_last = s_last;
    case (r_state)
      S_COLLECT: begin
        if (w_done) begin
          if (w_hold_free) w_xfer = 1'b1;
          else             w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        w_xfer_data = r_coll;
        w_xfer_cnt  = r_cnt;
        w_xfer_last = r_last;
        if (w_hold_free) begin
          w_xfer     = 1'b1;
          w_state_nx = S_COLLECT;
        end
      end
      default: w_state_nx = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_coll <= '0;
      r_last <= 1'b0;
    end else if (w_xfer) begin
      r_cnt  <= '0;
      r_coll <= '0;
      r_last <= 1'b0;
    end else if (w_acc) begin
      r_cnt  <= r_cnt + CW'(1);
      r_coll <= w_coll_ins;
      r_last <= s_last;
    end
  end

  // drain without a refill only drops valid; payload stays put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a       <= '0;
      r_a_cnt   <= '0;
      r_a_last  <= 1'b0;
    end else if (w_xfer) begin
      r_a_valid <= 1'b1;
      r_a       <= w_xfer_data;
      r_a_cnt   <= w_xfer_cnt;
      r_a_last  <= w_xfer_last;
    end else if (a_ready) begin
      r_a_valid <= 1'b0;
    end
  end

  assign a_valid = r_a_valid;
  assign a       = r_a;
  assign a_cnt   = r_a_cnt;
  assign a_last  = r_a_last;
endmodule

// File: tb/tb_score_packer.sv
// Directed bench for score_packer: table of group vectors plus multi-cycle stall/reset sequences.
module tb_score_packer;
  localparam int NUM = 18;
  localparam int LEN = 16;
  localparam int CW  = $clog2(NUM+1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_valid, s_ready, s_last;
  logic [LEN-1:0]     s_data;
  logic               a_valid, a_ready, a_last;
  logic [NUM*LEN-1:0] a;
  logic [CW-1:0]      a_cnt;
  logic [LEN-1:0]     thresh;

  int checks = 0;
  int errors = 0;

  score_packer #(.NUM(NUM), .LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .a_valid(a_valid), .a_ready(a_ready), .a(a), .a_cnt(a_cnt), .a_last(a_last)
`ifdef SCORE_PACKER_THRESH_EN
    , .thresh(thresh)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    int         base;
    int         step;
    bit         last;
    int         exp_cnt;
    bit         exp_last;
    logic [15:0] exp_first;
    logic [15:0] exp_end;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LEN-1:0] slot(input int k);
    return a[(NUM-1-k)*LEN +: LEN];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [LEN-1:0] d, input bit l);
    int t;
    t = 0;
    while (!s_ready && t < 50) begin tick(); t++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready stuck at 0 expected 1");
    end
    s_valid = 1'b1; s_data = d; s_last = l;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int stalls, pulses;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; a_ready = 1'b0; thresh = '0;

    tbl[0] = '{5,  100,   100, 1'b1, 5,  1'b1, 16'd100,   16'd500};
    tbl[1] = '{18, 1,     1,   1'b1, 18, 1'b1, 16'd1,     16'd18};
    tbl[2] = '{1,  65535, 0,   1'b1, 1,  1'b1, 16'hFFFF,  16'hFFFF};
    tbl[3] = '{18, 256,   2,   1'b0, 18, 1'b0, 16'h0100,  16'h0122};
    tbl[4] = '{3,  7,     3,   1'b1, 3,  1'b1, 16'd7,     16'd13};

    // reset state
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_cnt",   a_cnt,   0);
    chk("rst_a_last",  a_last,  0);
    chk("rst_a_zero",  (a == '0), 1);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_s_ready_pre", s_ready, 0);
    tick();
    chk("rel_s_ready_post", s_ready, 1);

    // 0..17 full group with a_ready high
    a_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < NUM; i++) begin
      if (!s_ready) stalls++;
      send(LEN'(i), 1'b0);
    end
    chk("full_stalls",  stalls, 0);
    chk("full_a_valid", a_valid, 1);
    chk("full_slot0",   slot(0), 0);
    chk("full_slot17",  slot(17), 17);
    chk("full_cnt",     a_cnt, 18);
    chk("full_last",    a_last, 0);
    tick();
    chk("full_drop",    a_valid, 0);
    chk("full_keep17",  slot(17), 17);
    chk("full_keepcnt", a_cnt, 18);

    // table of groups
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < tbl[r].n; j++)
        send(LEN'(tbl[r].base + j*tbl[r].step), tbl[r].last && (j == tbl[r].n-1));
      chk($sformatf("t%0d_valid", r), a_valid, 1);
      chk($sformatf("t%0d_cnt", r),   a_cnt,   tbl[r].exp_cnt);
      chk($sformatf("t%0d_last", r),  a_last,  tbl[r].exp_last);
      chk($sformatf("t%0d_first", r), slot(0), tbl[r].exp_first);
      chk($sformatf("t%0d_end", r),   slot(tbl[r].exp_cnt-1), tbl[r].exp_end);
      if (tbl[r].exp_cnt < NUM) begin
        chk($sformatf("t%0d_pad", r),  slot(tbl[r].exp_cnt), 0);
        chk($sformatf("t%0d_padN", r), slot(NUM-1), 0);
      end
      tick();
      chk($sformatf("t%0d_drop", r), a_valid, 0);
    end

    // hold stall: 36 words with a_ready low
    a_ready = 1'b0;
    for (int i = 0; i < 2*NUM; i++) begin
      send(LEN'(1000 + i), 1'b0);
      if (i == NUM-1) chk("hold_first_valid", a_valid, 1);
    end
    chk("wait_s_ready", s_ready, 0);
    chk("wait_a_valid", a_valid, 1);
    chk("wait_slot0",   slot(0), 1000);
    chk("wait_slot17",  slot(17), 1017);
    tick(); tick();
    chk("wait2_s_ready", s_ready, 0);
    chk("wait2_slot0",   slot(0), 1000);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("swap_valid",   a_valid, 1);
    chk("swap_slot0",   slot(0), 1018);
    chk("swap_slot17",  slot(17), 1035);
    chk("swap_cnt",     a_cnt, 18);
    chk("swap_s_ready", s_ready, 1);
    tick();
    chk("swap_hold",    a_valid, 1);
    a_ready = 1'b1;
    tick();
    chk("swap_drain",   a_valid, 0);

    // back-to-back 72 words, a_valid must pulse each 18th cycle
    stalls = 0; pulses = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 4*NUM; i++) begin
      if (!s_ready) stalls++;
      s_data = LEN'(3000 + i);
      tick();
      if (a_valid) pulses++;
      chk($sformatf("b2b_v%0d", i), a_valid, ((i+1) % NUM) == 0);
    end
    s_valid = 1'b0;
    chk("b2b_stalls", stalls, 0);
    chk("b2b_pulses", pulses, 4);
    chk("b2b_slot0",  slot(0), 3054);
    tick();

    // reset mid-group, then mid-hold
    for (int i = 0; i < 7; i++) send(LEN'(500 + i), 1'b0);
    rst_n = 1'b0; #1;
    chk("rstg_a_valid", a_valid, 0);
    chk("rstg_s_ready", s_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    a_ready = 1'b0;
    for (int i = 0; i < NUM; i++) send(LEN'(2000 + i), 1'b0);
    chk("rsth_valid", a_valid, 1);
    chk("rsth_slot0", slot(0), 2000);
    chk("rsth_slot17", slot(17), 2017);
    rst_n = 1'b0; #1;
    chk("rsth_a_valid", a_valid, 0);
    chk("rsth_a_cnt",   a_cnt, 0);
    chk("rsth_a_zero",  (a == '0), 1);
    @(negedge clk); rst_n = 1'b1;
    tick();
    a_ready = 1'b1;
    for (int i = 0; i < NUM; i++) send(LEN'(4000 + i), 1'b0);
    chk("fresh_valid",  a_valid, 1);
    chk("fresh_slot0",  slot(0), 4000);
    chk("fresh_slot17", slot(17), 4017);
    chk("fresh_cnt",    a_cnt, 18);
    tick();

`ifdef SCORE_PACKER_THRESH_EN
    thresh = 16'd50;
    send(16'd10, 1'b0); send(16'd60, 1'b0); send(16'd49, 1'b0); send(16'd50, 1'b1);
    chk("th_valid", a_valid, 1);
    chk("th_s0",    slot(0), 0);
    chk("th_s1",    slot(1), 60);
    chk("th_s2",    slot(2), 0);
    chk("th_s3",    slot(3), 50);
    chk("th_cnt",   a_cnt, 4);
    chk("th_last",  a_last, 1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_packer.md
Name: score_packer

Overview:
- Upstream feeder for the max-reduction tree in AdderTree_SortingTree.
- Collects a serial stream of LEN-bit keypoint scores (valid/ready) into a packed NUM*LEN vector, then presents it to the tree with a valid/ready handshake.
- Double-buffered: one collect register plus one hold register, so the next group fills while the previous group is being consumed.
- Handles short groups at end of window (s_last), padding the unused slots with zeros; zero is neutral for the tree's unsigned max.

Parameters:
- NUM, 18, words per packed group (>=2)
- LEN, 16, score width in bits, unsigned
- CW, $clog2(NUM+1), width of the word-count fields

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  input score valid
- s_ready  output  1  packer can accept a score
- s_data  input  LEN  input score, unsigned
- s_last  input  1  last score of the window; closes the group early
- a_valid  output  1  packed group valid in the hold register
- a_ready  input  1  downstream (max tree) accepts the group
- a  output  NUM*LEN  packed group
- a_cnt  output  CW  number of real words in a (1..NUM)
- a_last  output  1  group was closed by s_last

Behaviour:
- Reset (async, rst_n=0): state=COLLECT, collect count=0, collect reg=0, a=0, a_valid=0, a_cnt=0, a_last=0, s_ready=0 while in reset. s_ready=1 from the first edge after release.
- Accept: a score is accepted on a rising edge where s_valid && s_ready.
- Packing order:
  - The first accepted word of a group occupies a[NUM*LEN-1 -: LEN]; the k-th word (k=0..NUM-1) occupies a[(NUM-k)*LEN-1 -: LEN].
  - Unfilled slots are 0.
- Group completes when the accepted word brings the count to NUM, or when the accepted word carries s_last=1 (the earlier of the two).
- hold_free = !a_valid || a_ready, evaluated in the cycle of the completing accept.
- State COLLECT:
  - s_ready=1.
  - Non-completing accept: store the word, count++.
  - Completing accept with hold_free: on the same edge, load the hold register with the group (including this word), set a_valid=1, a_cnt=count+1, a_last=s_last, clear the collect reg and count. Stay in COLLECT.
  - Completing accept with !hold_free: store the word, latch the last flag, go to WAIT.
- State WAIT:
  - s_ready=0.
  - On the first edge where hold_free=1, transfer the collect reg to the hold register (same a_cnt/a_last rules), clear the collect side, return to COLLECT.
- Hold handshake:
  - a, a_cnt and a_last are stable while a_valid && !a_ready.
  - On a_valid && a_ready with no transfer on the same edge, a_valid drops to 0; a, a_cnt and a_last keep their values.
  - A transfer and a drain on the same edge: new data replaces old, and a_valid stays 1 (back-to-back full throughput).
- Latency: a_valid rises on the same edge that accepts the completing word (data registered, 1 cycle to visible).
- Throughput: with a_ready held high, one group every NUM accepted words, with no input stalls.
- s_last on the NUM-th word: a full group with a_cnt=NUM and a_last=1.
- s_data width: stored unchanged. No arithmetic other than the count (saturates at NUM by construction).
- Reset mid-operation: partial groups and the hold register are discarded; a_valid deasserts immediately (asynchronous).

Optional Feature:
- Macro: SCORE_PACKER_THRESH_EN.
- When defined:
  - Adds input port thresh (LEN bits, quasi-static).
  - An accepted s_data strictly below thresh is stored as 0 (non-max suppression floor).
  - The slot is still consumed and counted in a_cnt.
- When undefined: no thresh port; all words are stored unmodified.

Test Plan:
- Reset, then stream 0..17 with a_ready=1 -> a_valid for 1 cycle after the 18th accept; a[287:272]=0, a[15:0]=17, a_cnt=18, a_last=0; s_ready never drops.
- Stream 5 words 100,200,300,400,500 with s_last on 500 -> a[287:208]={100,200,300,400,500}, remaining slots 0, a_cnt=5, a_last=1.
- a_ready=0, stream 36 words -> first group held stable; s_ready=0 after the 36th accept (WAIT). Raise a_ready for 1 cycle -> second group appears in a and a_valid stays 1; s_ready=1 again.
- a_ready=1 continuously, 72 words back to back -> 4 groups, each a_valid pulse 1 cycle, zero input stall cycles.
- Assert rst_n=0 mid-group (after 7 words) and mid-hold -> a_valid=0 immediately. After release, a fresh 18-word stream packs from slot 0 with no residue.
- With SCORE_PACKER_THRESH_EN and thresh=50, stream 10,60,49,50 + s_last -> slots {0,60,0,50}, a_cnt=4.
